// File: rtl/div_seq_ctrl.sv
// Sequencer in front of the RV32M iterative divider: resolves divide-by-zero and signed
// overflow locally, feeds magnitudes to the core, fixes result signs and keeps a one-entry cache.
module div_seq_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        flush_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_data_o,
    output logic        core_start_o,
    output logic [31:0] core_dividend_o,
    output logic [31:0] core_divisor_o,
    input  logic        core_done_i,
    input  logic [31:0] core_quotient_i,
    input  logic [31:0] core_remainder_i
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    function automatic logic [31:0] sign_fix(input logic [31:0] val, input logic neg);
        sign_fix = neg ? (32'd0 - val) : val;
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic        w_accept;

    logic        r_cache_vld;
    logic [31:0] r_cache_op1;
    logic [31:0] r_cache_op2;
    logic        r_cache_signed;
    logic [31:0] r_cache_q;
    logic [31:0] r_cache_r;

    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic        r_signed;
    logic        r_is_rem;
    logic        r_sign1;
    logic        r_sign2;

    logic [31:0] r_resp_data;
    logic [31:0] r_core_dividend;
    logic [31:0] r_core_divisor;

    // Funct3 values outside 1xx decode as DIVU, so signed/rem need funct3[2] set.
    logic        w_signed;
    logic        w_is_rem;
    logic        w_sign1;
    logic        w_sign2;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic        w_div_zero;
    logic        w_overflow;
    logic        w_special;
    logic        w_hit;
    logic [31:0] w_special_data;
    logic [31:0] w_hit_data;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    logic        w_core_wb;

    assign w_signed   = funct3_i[2] & ~funct3_i[0];
    assign w_is_rem   = funct3_i[2] & funct3_i[1];
    assign w_sign1    = w_signed & op1_i[31];
    assign w_sign2    = w_signed & op2_i[31];
    assign w_mag1     = sign_fix(op1_i, w_sign1);
    assign w_mag2     = sign_fix(op2_i, w_sign2);
    assign w_div_zero = (op2_i == 32'd0);
    assign w_overflow = w_signed && (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF);
    assign w_special  = w_div_zero | w_overflow;
    assign w_hit      = r_cache_vld && (op1_i == r_cache_op1) && (op2_i == r_cache_op2)
                        && (w_signed == r_cache_signed);

    assign w_special_data = w_div_zero ? (w_is_rem ? op1_i : 32'hFFFF_FFFF)
                                       : (w_is_rem ? 32'd0 : 32'h8000_0000);
    assign w_hit_data     = w_is_rem ? r_cache_r : r_cache_q;

    assign w_q_fix   = sign_fix(core_quotient_i, r_sign1 ^ r_sign2);
    assign w_r_fix   = sign_fix(core_remainder_i, r_sign1);
    assign w_core_wb = (r_state == WAIT) && core_done_i && !flush_i;

    assign req_ready_o     = (r_state == IDLE);
    assign resp_valid_o    = (r_state == RESP);
    assign core_start_o    = (r_state == START);
    assign resp_data_o     = r_resp_data;
    assign core_dividend_o = r_core_dividend;
    assign core_divisor_o  = r_core_divisor;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A flush that coincides with core_done_i in WAIT has nothing left to drain.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!flush_i && req_valid_i) begin
                    w_accept     = 1'b1;
                    w_next_state = (w_special || w_hit) ? RESP : START;
                end
            end
            START: w_next_state = flush_i ? DRAIN : WAIT;
            WAIT: begin
                if (flush_i) begin
                    w_next_state = core_done_i ? IDLE : DRAIN;
                end else if (core_done_i) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (flush_i || resp_ready_i) begin
                    w_next_state = IDLE;
                end
            end
            DRAIN: begin
                if (core_done_i) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_resp_data     <= 32'd0;
            r_core_dividend <= 32'd0;
            r_core_divisor  <= 32'd0;
            r_cache_vld     <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_special) begin
                    r_resp_data <= w_special_data;
                end else if (w_hit) begin
                    r_resp_data <= w_hit_data;
                end else begin
                    r_core_dividend <= w_mag1;
                    r_core_divisor  <= w_mag2;
                end
            end
            if (w_core_wb) begin
                r_resp_data <= r_is_rem ? w_r_fix : w_q_fix;
                r_cache_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_op1    <= op1_i;
            r_op2    <= op2_i;
            r_signed <= w_signed;
            r_is_rem <= w_is_rem;
            r_sign1  <= w_sign1;
            r_sign2  <= w_sign2;
        end
        if (w_core_wb) begin
            r_cache_op1    <= r_op1;
            r_cache_op2    <= r_op2;
            r_cache_signed <= r_signed;
            r_cache_q      <= w_q_fix;
            r_cache_r      <= w_r_fix;
        end
    end

endmodule
